// File: rtl/conv_pkg.sv
// Shared definitions for the streaming convolutional encoder and its decoder-side users:
// size defaults, FSM state encoding, rate selectors and the reference parity function.
package conv_pkg;

    localparam int DEF_K_MAX     = 9;
    localparam int DEF_N_MAX     = 3;
    localparam int DEF_FRAME_LEN = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_e;

    localparam logic CODE_RATE_2 = 1'b0;
    localparam logic CODE_RATE_3 = 1'b1;

    // Bit i of the result is the parity of shift-register vector r masked by polynomial i.
    function automatic logic [DEF_N_MAX-1:0] conv_parity(
        input logic [DEF_N_MAX-1:0][DEF_K_MAX-1:0] poly,
        input logic [DEF_K_MAX-1:0]                r
    );
        logic [DEF_N_MAX-1:0] cw;
        cw = '0;
        for (int i = 0; i < DEF_N_MAX; i++) begin
            cw[i] = ^(r & poly[i]);
        end
        return cw;
    endfunction

endpackage

// File: rtl/conv_encoder_stream_if.sv
// Bit-in / codeword-out stream bundle of the convolutional encoder.
// The slave modport is the encoder view, the master modport the source/sink view.
interface conv_encoder_stream_if #(
    parameter int N_MAX = 3
) ();
    logic             i_in_valid;
    logic             i_in_data;
    logic             o_in_ready;
    logic             o_out_valid;
    logic [N_MAX-1:0] o_out_data;
    logic [N_MAX-1:0] o_out_mask;
    logic             o_out_last;
    logic             i_out_ready;

    modport slave (
        input  i_in_valid, i_in_data, i_out_ready,
        output o_in_ready, o_out_valid, o_out_data, o_out_mask, o_out_last
    );

    modport master (
        output i_in_valid, i_in_data, i_out_ready,
        input  o_in_ready, o_out_valid, o_out_data, o_out_mask, o_out_last
    );
endinterface

// File: rtl/conv_out_reg.sv
// One-entry valid/ready register carrying codeword data, lane mask and last flag.
// load_ready is high whenever the slot is empty or being drained this cycle.
module conv_out_reg #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    input  logic [W-1:0] load_mask,
    input  logic         load_last,
    output logic         load_ready,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [W-1:0] out_mask,
    output logic         out_last
);
    logic         valid_reg;
    logic [W-1:0] data_reg;
    logic [W-1:0] mask_reg;
    logic         last_reg;

    assign load_ready = !valid_reg || out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            mask_reg  <= '0;
            last_reg  <= 1'b0;
        end else if (load_ready) begin
            // An empty slot is zeroed so idle outputs never show stale codewords.
            valid_reg <= load_valid;
            data_reg  <= load_valid ? load_data : '0;
            mask_reg  <= load_valid ? load_mask : '0;
            last_reg  <= load_valid && load_last;
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_mask  = mask_reg;
    assign out_last  = last_reg;
endmodule

// File: rtl/conv_encoder_stream.sv
// Framed streaming convolutional encoder (rate 1/2 or 1/3, K-1 zero tail bits per frame).
// Build option PUNCTURE_EN adds i_punct for rate-2/3 puncturing of rate-1/2 data symbols.
module conv_encoder_stream
    import conv_pkg::*;
#(
    parameter int K_MAX     = DEF_K_MAX,
    parameter int N_MAX     = DEF_N_MAX,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_MAX-1:0][K_MAX-1:0]       i_gen_poly,
    input  logic                              i_code_rate,
    input  logic [3:0]                        i_k,
    input  logic                              i_start,
`ifdef PUNCTURE_EN
    input  logic                              i_punct,
`endif
    conv_encoder_stream_if.slave              bus,
    output logic                              o_busy
);
    localparam int CW = $clog2(FRAME_LEN + K_MAX);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_DATA = DATA;
    localparam logic [1:0] ST_TAIL = TAIL;

    logic [1:0]                  state_reg;
    logic [K_MAX-2:0]            sr_reg;
    logic [N_MAX-1:0][K_MAX-1:0] poly_reg;
    logic                        rate_reg;
    logic [3:0]                  k_reg;
    logic [CW-1:0]               cnt_reg;
`ifdef PUNCTURE_EN
    logic                        punct_reg;
`endif

    logic             adv;
    logic             bit_in;
    logic             fire;
    logic [K_MAX-1:0] enc_vec;
    logic [N_MAX-1:0] parity;
    logic [N_MAX-1:0] lane_en;
    logic [N_MAX-1:0] cw_mask;
    logic [N_MAX-1:0] cw_data;
    logic             cw_last;
    logic             punct_now;
    logic             end_data;
    logic             end_tail;

    // Tail symbols need no input handshake: they fire on every advance slot.
    assign bit_in  = (state_reg == ST_DATA) ? bus.i_in_data : 1'b0;
    assign fire    = ((state_reg == ST_DATA) && bus.i_in_valid && adv) ||
                     ((state_reg == ST_TAIL) && adv);
    assign enc_vec = {sr_reg, bit_in};

    genvar gi;
    generate
        for (gi = 0; gi < N_MAX; gi++) begin : g_lane
            assign parity[gi] = ^(enc_vec & poly_reg[gi]);
            if (gi < 2) begin : g_base
                assign lane_en[gi] = 1'b1;
            end else if (gi == 2) begin : g_third
                assign lane_en[gi] = (rate_reg == CODE_RATE_3);
            end else begin : g_unused
                assign lane_en[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef PUNCTURE_EN
    // Odd-indexed data symbols drop lane 1; the tail keeps full rate for clean termination.
    assign punct_now = punct_reg && (rate_reg == CODE_RATE_2) &&
                       (state_reg == ST_DATA) && cnt_reg[0];
`else
    assign punct_now = 1'b0;
`endif

    always_comb begin
        cw_mask = lane_en;
        if (punct_now) begin
            cw_mask[1] = 1'b0;
        end
    end

    assign cw_data  = parity & cw_mask;
    assign end_data = (cnt_reg == CW'(FRAME_LEN - 1));
    assign end_tail = (cnt_reg == CW'(FRAME_LEN - 2) + CW'(k_reg));
    assign cw_last  = (state_reg == ST_TAIL) && end_tail;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            sr_reg    <= '0;
            poly_reg  <= '0;
            rate_reg  <= CODE_RATE_2;
            k_reg     <= '0;
            cnt_reg   <= '0;
`ifdef PUNCTURE_EN
            punct_reg <= 1'b0;
`endif
        end else if (state_reg == ST_IDLE) begin
            if (i_start) begin
                poly_reg  <= i_gen_poly;
                rate_reg  <= i_code_rate;
                k_reg     <= i_k;
                sr_reg    <= '0;
                cnt_reg   <= '0;
`ifdef PUNCTURE_EN
                punct_reg <= i_punct;
`endif
                state_reg <= ST_DATA;
            end
        end else if (fire) begin
            // cnt_reg counts every symbol of the frame, data and tail alike.
            sr_reg  <= enc_vec[K_MAX-2:0];
            cnt_reg <= cnt_reg + CW'(1);
            if (state_reg == ST_DATA && end_data) begin
                state_reg <= ST_TAIL;
            end else if (state_reg == ST_TAIL && end_tail) begin
                state_reg <= ST_IDLE;
            end else if (state_reg != ST_DATA && state_reg != ST_TAIL) begin
                state_reg <= ST_IDLE;
            end
        end else if (state_reg != ST_DATA && state_reg != ST_TAIL) begin
            state_reg <= ST_IDLE;
        end
    end

    conv_out_reg #(
        .W(N_MAX)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load_valid(fire),
        .load_data (cw_data),
        .load_mask (cw_mask),
        .load_last (cw_last),
        .load_ready(adv),
        .out_ready (bus.i_out_ready),
        .out_valid (bus.o_out_valid),
        .out_data  (bus.o_out_data),
        .out_mask  (bus.o_out_mask),
        .out_last  (bus.o_out_last)
    );

    assign bus.o_in_ready = (state_reg == ST_DATA) && adv;
    assign o_busy         = (state_reg != ST_IDLE) || bus.o_out_valid;
endmodule

// File: tb/tb_conv_encoder_stream.sv
// Directed bench for conv_encoder_stream: reset, hand-computed codewords, tail/last,
// rate masks, random backpressure against a reference encoder, and puncturing when built with it.
module tb_conv_encoder_stream;
    import conv_pkg::*;

    localparam int K_MAX     = 9;
    localparam int N_MAX     = 3;
    localparam int FRAME_LEN = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N_MAX-1:0][K_MAX-1:0] i_gen_poly = '0;
    logic                        i_code_rate = 1'b0;
    logic [3:0]                  i_k = 4'd0;
    logic                        i_start = 1'b0;
    logic                        o_busy;
`ifdef PUNCTURE_EN
    logic                        i_punct = 1'b0;
`endif

    conv_encoder_stream_if #(.N_MAX(N_MAX)) bus ();

    conv_encoder_stream #(
        .K_MAX    (K_MAX),
        .N_MAX    (N_MAX),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_gen_poly (i_gen_poly),
        .i_code_rate(i_code_rate),
        .i_k        (i_k),
        .i_start    (i_start),
`ifdef PUNCTURE_EN
        .i_punct    (i_punct),
`endif
        .bus        (bus),
        .o_busy     (o_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: records accepted codewords and watches stall behaviour.
    logic [N_MAX-1:0] got_data[$];
    logic [N_MAX-1:0] got_mask[$];
    logic             got_last[$];
    int               stall_err = 0;
    int               ready_err = 0;
    logic             rand_ready = 1'b0;

    initial begin
        logic             prev_stall;
        logic [N_MAX-1:0] prev_data;
        logic [N_MAX-1:0] prev_mask;
        logic             prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_mask  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!bus.o_out_valid || bus.o_out_data !== prev_data ||
                                   bus.o_out_mask !== prev_mask || bus.o_out_last !== prev_last))
                    stall_err++;
                if (bus.o_out_valid && !bus.i_out_ready && bus.o_in_ready)
                    ready_err++;
                if (bus.o_out_valid && bus.i_out_ready) begin
                    got_data.push_back(bus.o_out_data);
                    got_mask.push_back(bus.o_out_mask);
                    got_last.push_back(bus.o_out_last);
                end
                prev_stall = bus.o_out_valid && !bus.i_out_ready;
                prev_data  = bus.o_out_data;
                prev_mask  = bus.o_out_mask;
                prev_last  = bus.o_out_last;
            end
        end
    end

    // Sole driver of i_out_ready: always 1 unless random backpressure is enabled.
    initial begin
        bus.i_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.i_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic             in_bits[$];
    logic [N_MAX-1:0] exp_data[$];
    logic [N_MAX-1:0] exp_mask[$];
    logic             exp_last[$];

    // Independent reference encoder: history word shifted left, newest bit at bit 0.
    task automatic build_expected(input logic [K_MAX-1:0] p0, input logic [K_MAX-1:0] p1,
                                  input logic [K_MAX-1:0] p2, input logic rate,
                                  input int k, input logic punct);
        logic [K_MAX-1:0] hist;
        logic [2:0]       d;
        logic [2:0]       m;
        logic             b;
        hist = '0;
        exp_data.delete();
        exp_mask.delete();
        exp_last.delete();
        for (int s = 0; s < FRAME_LEN + k - 1; s++) begin
            b    = (s < FRAME_LEN) ? in_bits[s] : 1'b0;
            hist = {hist[K_MAX-2:0], b};
            d[0] = ^(hist & p0);
            d[1] = ^(hist & p1);
            d[2] = ^(hist & p2);
            m    = rate ? 3'b111 : 3'b011;
            if (punct && !rate && s < FRAME_LEN && (s % 2) == 1) m = 3'b001;
            exp_data.push_back(d & m);
            exp_mask.push_back(m);
            exp_last.push_back(s == FRAME_LEN + k - 2);
        end
    endtask

    task automatic start_frame(input logic [K_MAX-1:0] p0, input logic [K_MAX-1:0] p1,
                               input logic [K_MAX-1:0] p2, input logic rate,
                               input logic [3:0] k, input logic punct);
        @(posedge clk);
        #1;
        i_gen_poly[0] = p0;
        i_gen_poly[1] = p1;
        i_gen_poly[2] = p2;
        i_code_rate   = rate;
        i_k           = k;
`ifdef PUNCTURE_EN
        i_punct       = punct;
`endif
        i_start       = 1'b1;
        @(posedge clk);
        #1;
        // Scramble config afterwards: only the start-time values may matter.
        i_start       = 1'b0;
        i_gen_poly    = '1;
        i_code_rate   = ~rate;
        i_k           = 4'd9;
`ifdef PUNCTURE_EN
        i_punct       = ~punct;
`endif
    endtask

    task automatic send_bit(input logic b);
        int n;
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_in_ready && n < 2000);
        if (!bus.o_in_ready) check("in_ready_timeout", 32'(bus.o_in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.i_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_busy && n < 5000);
        if (o_busy) check({tag, "_idle_timeout"}, 32'(o_busy), 32'd0);
    endtask

    task automatic compare_stream(input string tag);
        int bad;
        bad = 0;
        check({tag, "_count"}, 32'(got_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size(); i++) begin
            if (i >= got_data.size()) bad++;
            else if (got_data[i] !== exp_data[i] || got_mask[i] !== exp_mask[i] ||
                     got_last[i] !== exp_last[i]) bad++;
        end
        check({tag, "_stream"}, 32'(bad), 32'd0);
        $display("frame %s symbols=%0d mismatched=%0d", tag, got_data.size(), bad);
    endtask

    task automatic clear_capture();
        got_data.delete();
        got_mask.delete();
        got_last.delete();
    endtask

    initial begin
        int bad;
        int lasts;
        bus.i_in_valid = 1'b0;
        bus.i_in_data  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(bus.o_in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
        check("rst_out_data",  32'(bus.o_out_data),  32'd0);
        check("rst_out_mask",  32'(bus.o_out_mask),  32'd0);
        check("rst_out_last",  32'(bus.o_out_last),  32'd0);
        check("rst_busy",      32'(o_busy),          32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Reset in the middle of a frame discards it
        start_frame(9'o7, 9'o5, 9'o0, CODE_RATE_2, 4'd3, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.o_out_valid), 32'd0);
        check("midrst_out_data",  32'(bus.o_out_data),  32'd0);
        check("midrst_busy",      32'(o_busy),          32'd0);
        check("midrst_in_ready",  32'(bus.o_in_ready),  32'd0);
        clear_capture();

        // K=3, polys 7,5, rate 1/2, inputs 1,0,1,1 then zeros
        in_bits.delete();
        for (int i = 0; i < FRAME_LEN; i++) in_bits.push_back(1'b0);
        in_bits[0] = 1'b1; in_bits[2] = 1'b1; in_bits[3] = 1'b1;
        start_frame(9'o7, 9'o5, 9'o0, CODE_RATE_2, 4'd3, 1'b0);
        for (int i = 0; i < FRAME_LEN; i++) send_bit(in_bits[i]);
        wait_idle("r12");
        check("r12_cw0", 32'(got_data[0]), 32'h3);
        check("r12_cw1", 32'(got_data[1]), 32'h1);
        check("r12_cw2", 32'(got_data[2]), 32'h0);
        check("r12_cw3", 32'(got_data[3]), 32'h2);
        check("r12_cw4", 32'(got_data[4]), 32'h2);
        check("r12_cw5", 32'(got_data[5]), 32'h3);
        check("r12_mask0", 32'(got_mask[0]), 32'h3);
        check("r12_total", 32'(got_data.size()), 32'd130);
        check("r12_last129", 32'(got_last[129]), 32'd1);
        check("r12_last128", 32'(got_last[128]), 32'd0);
        build_expected(9'o7, 9'o5, 9'o0, CODE_RATE_2, 3, 1'b0);
        compare_stream("r12");
        clear_capture();

        // Rate 1/3, polys 7,5,3, inputs 1,1,0,1 then zeros
        in_bits.delete();
        for (int i = 0; i < FRAME_LEN; i++) in_bits.push_back(1'b0);
        in_bits[0] = 1'b1; in_bits[1] = 1'b1; in_bits[3] = 1'b1;
        start_frame(9'o7, 9'o5, 9'o3, CODE_RATE_3, 4'd3, 1'b0);
        for (int i = 0; i < FRAME_LEN; i++) send_bit(in_bits[i]);
        wait_idle("r13");
        check("r13_cw0", 32'(got_data[0]), 32'h7);
        check("r13_cw1", 32'(got_data[1]), 32'h2);
        check("r13_cw2", 32'(got_data[2]), 32'h6);
        check("r13_cw3", 32'(got_data[3]), 32'h4);
        bad = 0;
        foreach (got_mask[i]) if (got_mask[i] !== 3'b111) bad++;
        check("r13_mask_all", 32'(bad), 32'd0);
        build_expected(9'o7, 9'o5, 9'o3, CODE_RATE_3, 3, 1'b0);
        compare_stream("r13");
        clear_capture();

        // Random backpressure, K=5 polys 23,35 (octal), stray i_start mid-frame
        in_bits.delete();
        for (int i = 0; i < FRAME_LEN; i++) in_bits.push_back(1'($urandom_range(0, 1)));
        rand_ready = 1'b1;
        start_frame(9'o23, 9'o35, 9'o0, CODE_RATE_2, 4'd5, 1'b0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i == 50) begin
                @(posedge clk);
                #1 i_start = 1'b1;
                i_k = 4'd3;
                @(posedge clk);
                #1 i_start = 1'b0;
            end
            send_bit(in_bits[i]);
        end
        wait_idle("bp");
        rand_ready = 1'b0;
        check("bp_total", 32'(got_data.size()), 32'd132);
        check("bp_stall_stable", 32'(stall_err), 32'd0);
        check("bp_in_ready_stalled", 32'(ready_err), 32'd0);
        bad = 0;
        lasts = 0;
        foreach (got_data[i]) begin
            if (got_data[i][2] !== 1'b0 || got_mask[i] !== 3'b011) bad++;
            if (got_last[i]) lasts++;
        end
        check("bp_rate12_lane2", 32'(bad), 32'd0);
        check("bp_last_count", 32'(lasts), 32'd1);
        build_expected(9'o23, 9'o35, 9'o0, CODE_RATE_2, 5, 1'b0);
        compare_stream("bp");
        clear_capture();

`ifdef PUNCTURE_EN
        // Punctured rate 1/2 -> 2/3; tail stays unpunctured
        in_bits.delete();
        for (int i = 0; i < FRAME_LEN; i++) in_bits.push_back(1'($urandom_range(0, 1)));
        start_frame(9'o7, 9'o5, 9'o0, CODE_RATE_2, 4'd3, 1'b1);
        for (int i = 0; i < FRAME_LEN; i++) send_bit(in_bits[i]);
        wait_idle("pun");
        bad = 0;
        for (int i = 0; i < FRAME_LEN && i < got_mask.size(); i++) begin
            if (got_mask[i] !== ((i % 2 == 1) ? 3'b001 : 3'b011)) bad++;
            if ((i % 2 == 1) && got_data[i][1] !== 1'b0) bad++;
        end
        check("pun_data_masks", 32'(bad), 32'd0);
        check("pun_tail_mask0", 32'(got_mask[128]), 32'h3);
        check("pun_tail_mask1", 32'(got_mask[129]), 32'h3);
        build_expected(9'o7, 9'o5, 9'o0, CODE_RATE_2, 3, 1'b1);
        compare_stream("pun");
        clear_capture();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
